// File: rtl/mat_mul_pkg.sv
// rtl/mat_mul_pkg.sv - shared sizing defaults, strobe constant and feeder state encoding
package mat_mul_pkg;

    localparam int DIM_LOG_DEF    = 6;
    localparam int DATA_WIDTH_DEF = 32;

    // Wide enough for any stream width up to 1024 bits; users slice the low DATA_WIDTH/8 bits.
    localparam logic [127:0] STRB_ALL = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_A,
        ST_GAP,
        ST_SEND_B,
        ST_START,
        ST_FIN
    } feed_state_t;

    function automatic int words_per_matrix(input int dim_log);
        return 1 << (2 * dim_log);
    endfunction

endpackage

// File: rtl/mat_buf_ram.sv
// rtl/mat_buf_ram.sv - simple dual-port matrix buffer, one write port and one registered read port
module mat_buf_ram #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Read-first: a read of the address being written on the same edge returns the old word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mat_stream_feeder.sv
// rtl/mat_stream_feeder.sv - streams buffer A then buffer B to mat_mul over AXI-Stream, then pulses start
module mat_stream_feeder
    import mat_mul_pkg::*;
#(
    parameter int DIM_LOG    = DIM_LOG_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_areset,
    input  logic                    ld_en,
    input  logic                    ld_sel,
    input  logic [2*DIM_LOG-1:0]    ld_addr,
    input  logic [DATA_WIDTH-1:0]   ld_data,
    input  logic                    go,
    output logic                    m00_axis_tvalid,
    output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                    m00_axis_tlast,
    input  logic                    m00_axis_tready,
    output logic                    mat_sel,
    output logic                    mat_start,
    output logic                    busy,
    output logic                    done
);

    localparam int AW = 2 * DIM_LOG;
    localparam int CW = AW + 2;
    localparam int W  = words_per_matrix(DIM_LOG);
    localparam logic [AW-1:0] LAST_IDX  = AW'(W - 1);
    localparam logic [CW-1:0] ISS_A_END = CW'(W);
    localparam logic [CW-1:0] ISS_B_END = CW'(2 * W);

    feed_state_t state_q, state_d;

    logic [AW-1:0]         beat_cnt_q, beat_cnt_d;
    logic [CW-1:0]         iss_cnt_q, iss_cnt_d;
    logic                  rd_vld_q, rd_vld_d;
    logic                  rd_sel_q, rd_sel_d;
    logic                  tvalid_q, tvalid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  skid_vld_q, skid_vld_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

    logic [DATA_WIDTH-1:0] dout_a, dout_b, rd_data;
    logic                  accept, last_acc, wr_en, ren, issue_ok, room;
    logic [1:0]            occ;

    assign accept   = tvalid_q && m00_axis_tready;
    assign last_acc = accept && (beat_cnt_q == LAST_IDX);
    assign wr_en    = ld_en && (state_q == ST_IDLE);
    assign rd_data  = rd_sel_q ? dout_b : dout_a;

    mat_buf_ram #(.AW(AW), .DW(DATA_WIDTH)) u_buf_a (
        .clk_i   (s00_axi_aclk),
        .we_i    (wr_en && !ld_sel),
        .waddr_i (ld_addr),
        .wdata_i (ld_data),
        .re_i    (ren && !iss_cnt_q[AW]),
        .raddr_i (iss_cnt_q[AW-1:0]),
        .rdata_o (dout_a)
    );

    mat_buf_ram #(.AW(AW), .DW(DATA_WIDTH)) u_buf_b (
        .clk_i   (s00_axi_aclk),
        .we_i    (wr_en && ld_sel),
        .waddr_i (ld_addr),
        .wdata_i (ld_data),
        .re_i    (ren && iss_cnt_q[AW]),
        .raddr_i (iss_cnt_q[AW-1:0]),
        .rdata_o (dout_b)
    );

    // A read may only be issued if the word it returns is guaranteed a slot (output or skid).
    assign occ  = {1'b0, tvalid_q} + {1'b0, skid_vld_q} + {1'b0, rd_vld_q};
    assign room = (occ < 2'd2) || (accept && (occ == 2'd2));

    always_comb begin
        issue_ok = 1'b0;
        case (state_q)
            ST_SEND_A:         issue_ok = (iss_cnt_q < ISS_A_END) || last_acc;
            ST_GAP, ST_SEND_B: issue_ok = (iss_cnt_q < ISS_B_END);
            default:           issue_ok = 1'b0;
        endcase
    end

    assign ren        = issue_ok && room;
    assign iss_cnt_d  = (state_q == ST_IDLE) ? '0 : iss_cnt_q + CW'(ren);
    assign beat_cnt_d = beat_cnt_q + AW'(accept);
    assign rd_vld_d   = ren;
    assign rd_sel_d   = ren ? iss_cnt_q[AW] : rd_sel_q;

    always_comb begin
        tvalid_d    = tvalid_q;
        out_data_d  = out_data_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        if (!tvalid_q || accept) begin
            if (skid_vld_q) begin
                tvalid_d    = 1'b1;
                out_data_d  = skid_data_q;
                skid_vld_d  = rd_vld_q;
                skid_data_d = rd_vld_q ? rd_data : skid_data_q;
            end else begin
                tvalid_d   = rd_vld_q;
                out_data_d = rd_vld_q ? rd_data : out_data_q;
            end
        end else if (rd_vld_q) begin
            skid_vld_d  = 1'b1;
            skid_data_d = rd_data;
        end
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            state_q     <= ST_IDLE;
            beat_cnt_q  <= '0;
            iss_cnt_q   <= '0;
            rd_vld_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            tvalid_q    <= 1'b0;
            out_data_q  <= '0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            iss_cnt_q   <= iss_cnt_d;
            rd_vld_q    <= rd_vld_d;
            rd_sel_q    <= rd_sel_d;
            tvalid_q    <= tvalid_d;
            out_data_q  <= out_data_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (go) state_d = ST_SEND_A;
            ST_SEND_A: if (last_acc) state_d = ST_GAP;
            ST_GAP:    state_d = ST_SEND_B;
            ST_SEND_B: if (last_acc) state_d = ST_START;
            ST_START:  state_d = ST_FIN;
            ST_FIN:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mat_sel   = 1'b0;
        mat_start = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            ST_IDLE:           busy = 1'b0;
            ST_GAP, ST_SEND_B: mat_sel = 1'b1;
            ST_START: begin
                mat_sel   = 1'b1;
                mat_start = 1'b1;
            end
            ST_FIN: begin
                mat_sel = 1'b1;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

    assign m00_axis_tvalid = tvalid_q;
    assign m00_axis_tdata  = out_data_q;
    assign m00_axis_tlast  = tvalid_q && (beat_cnt_q == LAST_IDX);
    assign m00_axis_tstrb  = STRB_ALL[DATA_WIDTH/8-1:0];

endmodule

// File: tb/tb_mat_stream_feeder.sv
// tb/tb_mat_stream_feeder.sv - randomized self-checking bench for mat_stream_feeder with a queue-based reference
module tb_mat_stream_feeder;

    localparam int DL = 2;
    localparam int DW = 32;
    localparam int W  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_en, ld_sel, go;
    logic [2*DL-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          tvalid, tlast, tready;
    logic [DW-1:0] tdata;
    logic [DW/8-1:0] tstrb;
    logic          mat_sel, mat_start, busy, done;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] ref_a [W];
    logic [DW-1:0] ref_b [W];

    logic [DW-1:0] q_data [$];
    logic          q_last [$];
    logic          q_sel  [$];
    int stall_err, withdraw_err, gap_len, gap_sel_bad, lat, start_cnt, done_cnt;
    int start_cyc, done_cyc, start_sel_bad, start_tv, done_busy, busy_after_done;
    bit timeout;

    mat_stream_feeder #(.DIM_LOG(DL), .DATA_WIDTH(DW)) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_areset  (rst),
        .ld_en           (ld_en),
        .ld_sel          (ld_sel),
        .ld_addr         (ld_addr),
        .ld_data         (ld_data),
        .go              (go),
        .m00_axis_tvalid (tvalid),
        .m00_axis_tdata  (tdata),
        .m00_axis_tstrb  (tstrb),
        .m00_axis_tlast  (tlast),
        .m00_axis_tready (tready),
        .mat_sel         (mat_sel),
        .mat_start       (mat_start),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // Reference order: every A word in row-major order, then every B word.
    function automatic logic [DW-1:0] exp_word(input int i);
        return (i < W) ? ref_a[i] : ref_b[i-W];
    endfunction

    function automatic int seq_errors();
        int bad = 0;
        if (q_data.size() != 2*W) bad++;
        for (int i = 0; i < q_data.size() && i < 2*W; i++) begin
            if (q_data[i] !== exp_word(i) || q_last[i] !== (i % W == W-1)) bad++;
        end
        return bad;
    endfunction

    task automatic load_bufs();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < W; i++) begin
                @(negedge clk);
                ld_en = 1'b1; ld_sel = s[0]; ld_addr = i[2*DL-1:0];
                ld_data = (s == 0) ? ref_a[i] : ref_b[i];
            end
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Runs one full transfer and records what the stream and control outputs did; no judging here.
    task automatic collect(input int mode, input bit inject, input bit gl, input logic [DW-1:0] gl_data);
        int acc = 0;
        int gap_state = 0;
        logic pstall = 1'b0, plast = 1'b0;
        logic [DW-1:0] pdata = '0;
        q_data.delete(); q_last.delete(); q_sel.delete();
        stall_err = 0; withdraw_err = 0; gap_len = 0; gap_sel_bad = 0; lat = -1;
        start_cnt = 0; done_cnt = 0; start_cyc = -1; done_cyc = -1; start_sel_bad = 0;
        start_tv = 0; done_busy = -1; busy_after_done = -1; timeout = 0;
        @(negedge clk);
        go = 1'b1; tready = 1'b0;
        if (gl) begin
            ld_en = 1'b1; ld_sel = 1'b0; ld_addr = '0; ld_data = gl_data;
        end
        for (int cyc = 1; cyc < 400 && busy_after_done < 0; cyc++) begin
            @(negedge clk);
            go = 1'b0; ld_en = 1'b0;
            if (inject && cyc == 10) begin
                ld_en = 1'b1; ld_sel = 1'b0; ld_addr = '0; ld_data = 32'hDEAD; go = 1'b1;
            end
            case (mode)
                0:       tready = 1'b1;
                1:       tready = (cyc % 4 == 1) || (cyc % 4 == 0);
                default: tready = 1'($urandom_range(0, 1));
            endcase
            if (pstall && (!tvalid || tdata !== pdata || tlast !== plast)) stall_err++;
            if (tvalid && lat < 0) lat = cyc;
            if (!tvalid && (acc % W) != 0) withdraw_err++;
            if (gap_state == 1) begin
                if (!tvalid) begin
                    gap_len++;
                    if (!mat_sel) gap_sel_bad++;
                end else gap_state = 2;
            end
            if (mat_start) begin
                start_cnt++; start_cyc = cyc;
                if (!mat_sel) start_sel_bad++;
                if (tvalid) start_tv++;
            end
            if (done) begin
                done_cnt++; done_cyc = cyc; done_busy = int'(busy);
            end else if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                busy_after_done = int'(busy);
            end
            if (tvalid && tready) begin
                q_data.push_back(tdata); q_last.push_back(tlast); q_sel.push_back(mat_sel);
                acc++;
                if (acc == W) gap_state = 1;
            end
            pstall = tvalid && !tready; pdata = tdata; plast = tlast;
        end
        if (busy_after_done < 0) timeout = 1;
        tready = 1'b0; go = 1'b0; ld_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0; go = 1'b0; tready = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({tvalid, tlast, mat_sel, mat_start, busy, done} !== 6'b0) begin
            fails++; $display("FAIL reset_ctrl got %b expected 000000", {tvalid, tlast, mat_sel, mat_start, busy, done});
        end
        tests++;
        if (tdata !== '0) begin fails++; $display("FAIL reset_tdata got %h expected 0", tdata); end
        tests++;
        if (tstrb !== 4'hF) begin fails++; $display("FAIL tstrb got %h expected f", tstrb); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < W; i++) begin ref_a[i] = 32'(i + 1); ref_b[i] = 32'(100 + i); end
        load_bufs();
        collect(0, 0, 0, '0);
        tests++;
        if (timeout) begin fails++; $display("FAIL basic_timeout got no done expected done"); end
        tests++;
        if (q_data.size() != 2*W) begin fails++; $display("FAIL basic_count got %0d expected %0d", q_data.size(), 2*W); end
        for (int i = 0; i < q_data.size() && i < 2*W; i++) begin
            tests++;
            if (q_data[i] !== exp_word(i)) begin fails++; $display("FAIL basic_data[%0d] got %h expected %h", i, q_data[i], exp_word(i)); end
            tests++;
            if (q_last[i] !== (i % W == W-1)) begin fails++; $display("FAIL basic_tlast[%0d] got %b expected %b", i, q_last[i], (i % W == W-1)); end
        end
        tests++;
        if (lat < 1 || lat > 3) begin fails++; $display("FAIL go_latency got %0d expected 1..3", lat); end
        tests++;
        if (gap_len != 1) begin fails++; $display("FAIL gap_len got %0d expected 1", gap_len); end
        tests++;
        if (withdraw_err != 0) begin fails++; $display("FAIL basic_withdraw got %0d expected 0", withdraw_err); end
        tests++;
        if (start_cnt != 1 || start_tv != 0) begin fails++; $display("FAIL start_pulse got cnt=%0d tv=%0d expected 1/0", start_cnt, start_tv); end
        tests++;
        if (done_cnt != 1 || done_cyc != start_cyc + 1) begin
            fails++; $display("FAIL done_pulse got cnt=%0d at %0d expected 1 at %0d", done_cnt, done_cyc, start_cyc + 1);
        end
    endtask

    task automatic test_toggle();
        collect(1, 0, 0, '0);
        tests++;
        if (seq_errors() != 0 || timeout) begin fails++; $display("FAIL toggle_order got %0d bad beats expected 0", seq_errors()); end
        tests++;
        if (stall_err != 0) begin fails++; $display("FAIL toggle_stall got %0d unstable cycles expected 0", stall_err); end
        tests++;
        if (withdraw_err != 0 || gap_len != 1) begin fails++; $display("FAIL toggle_flow got withdraw=%0d gap=%0d expected 0/1", withdraw_err, gap_len); end
    endtask

    task automatic test_load_busy();
        collect(0, 1, 0, '0);
        tests++;
        if (seq_errors() != 0 || start_cnt != 1 || done_cnt != 1) begin
            fails++; $display("FAIL busy_run got bad=%0d start=%0d done=%0d expected 0/1/1", seq_errors(), start_cnt, done_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (busy !== 1'b0) begin fails++; $display("FAIL busy_go_ignored got busy=%b expected 0", busy); end
        end
        collect(0, 0, 0, '0);
        tests++;
        if (q_data.size() == 0 || q_data[0] !== ref_a[0]) begin
            fails++; $display("FAIL busy_write_dropped got %h expected %h", (q_data.size() > 0) ? q_data[0] : 32'hX, ref_a[0]);
        end
    endtask

    task automatic test_reset_mid();
        int acc = 0;
        @(negedge clk);
        go = 1'b1; tready = 1'b1;
        for (int c = 0; c < 100 && acc < 7; c++) begin
            @(negedge clk);
            go = 1'b0;
            if (tvalid && tready) acc++;
        end
        tests++;
        if (acc != 7) begin fails++; $display("FAIL rst_mid_reach got %0d beats expected 7", acc); end
        rst = 1'b1;
        #1;
        tests++;
        if ({tvalid, tlast, mat_sel, mat_start, busy, done} !== 6'b0 || tdata !== '0) begin
            fails++; $display("FAIL rst_mid_async got ctrl=%b data=%h expected 0/0", {tvalid, tlast, mat_sel, mat_start, busy, done}, tdata);
        end
        @(negedge clk);
        rst = 1'b0; tready = 1'b0;
        collect(0, 0, 0, '0);
        tests++;
        if (seq_errors() != 0 || timeout) begin fails++; $display("FAIL rst_mid_restart got %0d bad beats expected 0", seq_errors()); end
    endtask

    task automatic test_sel_busy();
        for (int i = 0; i < W; i++) begin ref_a[i] = $urandom; ref_b[i] = $urandom; end
        load_bufs();
        collect(2, 0, 0, '0);
        tests++;
        if (seq_errors() != 0 || timeout) begin fails++; $display("FAIL random_order got %0d bad beats expected 0", seq_errors()); end
        for (int i = 0; i < q_sel.size(); i++) begin
            tests++;
            if (q_sel[i] !== (i >= W)) begin fails++; $display("FAIL mat_sel_beat[%0d] got %b expected %b", i, q_sel[i], (i >= W)); end
        end
        tests++;
        if (start_sel_bad != 0 || gap_sel_bad != 0) begin fails++; $display("FAIL mat_sel_ctrl got %0d/%0d expected 0/0", start_sel_bad, gap_sel_bad); end
        tests++;
        if (done_busy != 1 || busy_after_done != 0) begin
            fails++; $display("FAIL busy_fall got %0d then %0d expected 1 then 0", done_busy, busy_after_done);
        end
        tests++;
        if (stall_err != 0) begin fails++; $display("FAIL random_stall got %0d expected 0", stall_err); end
    endtask

    task automatic test_go_with_load();
        logic [DW-1:0] nw;
        nw = $urandom;
        ref_a[0] = nw;
        collect(2, 0, 1, nw);
        tests++;
        if (seq_errors() != 0 || timeout) begin fails++; $display("FAIL go_load_order got %0d bad beats expected 0", seq_errors()); end
        tests++;
        if (q_data.size() == 0 || q_data[0] !== nw) begin
            fails++; $display("FAIL go_load_first got %h expected %h", (q_data.size() > 0) ? q_data[0] : 32'hX, nw);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_load_busy();
        test_reset_mid();
        test_sel_busy();
        test_go_with_load();
        test_sel_busy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
